// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generator feeding a 1-cycle instruction memory, with a FIFO_DEPTH-entry {pc, instr} queue toward decode.
// First instr valid 2 cycles after its issue; if_ready low holds the head and throttles issue; IF_PERF_CNT_EN adds perf counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_add,
  input  logic [31:0] imem_rdata,
  output logic [3:0]  imem_wen,
  output logic [31:0] imem_wdata,
  input  logic        fetch_en,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int          PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]   pc_q;
  logic [31:0]   inflight_pc_q;
  logic          inflight_q;
  fetch_entry_t  fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign imem_add   = pc_q;
  assign imem_wen   = 4'b0000;
  assign imem_wdata = 32'd0;

  assign if_valid = (count_q != '0) & ~redir_valid;
  assign if_pc    = fifo_q[rd_ptr_q].pc;
  assign if_instr = fifo_q[rd_ptr_q].instr;

  assign pop  = if_valid & if_ready;
  assign push = inflight_q & ~redir_valid;

  // Reserve a slot for the outstanding read so its response can never overflow the queue.
  assign occupancy = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = fetch_en & ~redir_valid & (occupancy < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC_W;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (redir_valid) begin
      pc_q       <= {redir_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {inflight_pc_q, imem_rdata};
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push & ~pop)      count_q <= count_q + CW'(1);
      else if (pop & ~push) count_q <= count_q - CW'(1);
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (push)                 perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_valid & ~if_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  overflow_chk: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule
